// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter advanced by rising edges of a slow square wave
// that is oversampled in the clk_in domain; start/stop FSM, clear, load, wrap or saturate.
module bcd_tick_counter #(
    parameter int NUM_DIGITS = 4,
    parameter bit WRAP_EN    = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    slow_clk_in,
    input  logic                    start_stop,
    input  logic                    up_down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count_out,
    output logic                    tick_out,
    output logic                    wrap_out,
    output logic                    running_out
);

    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         s1_q, s2_q, s3_q;
    logic         tick;
    logic [W:0]   step_res;

    // One-digit ripple step; the MSB of the result is the carry/borrow out of the top digit,
    // which is exactly the "stepped past a limit" condition.
    function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         c;
        logic [3:0]   d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                        c = 1'b1;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                        c = 1'b1;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    assign tick     = s2_q & ~s3_q;
    assign step_res = bcd_step(count_q, up_down);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (start_stop) state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = bcd_clamp(load_value);
        end else if (tick && state_q == RUNNING) begin
            if (step_res[W]) begin
                wrap_d = 1'b1;
                if (WRAP_EN) begin
                    count_d = step_res[W-1:0];
                end else begin
                    state_d = STOPPED;
                end
            end else begin
                count_d = step_res[W-1:0];
            end
        end
    end

    // Samplers reset high so a wave already high out of reset must go low before it ticks.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
            state_q <= STOPPED;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            s1_q    <= slow_clk_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out   = count_q;
    assign tick_out    = tick;
    assign wrap_out    = wrap_q;
    assign running_out = (state_q == RUNNING);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: one wrapping and one saturating instance on shared inputs.
module tb_bcd_tick_counter;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        slow_clk_in = 1'b1;
    logic        start_stop = 1'b0;
    logic        up_down = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;

    logic [15:0] w_count, s_count;
    logic        w_tick, w_wrap, w_run;
    logic        s_tick, s_wrap, s_run;

    int checks = 0;
    int errors = 0;

    bcd_tick_counter #(.NUM_DIGITS(4), .WRAP_EN(1'b1)) dut_w (
        .clk_in(clk_in), .rst_n(rst_n), .slow_clk_in(slow_clk_in), .start_stop(start_stop),
        .up_down(up_down), .clear(clear), .load(load), .load_value(load_value),
        .count_out(w_count), .tick_out(w_tick), .wrap_out(w_wrap), .running_out(w_run)
    );

    bcd_tick_counter #(.NUM_DIGITS(4), .WRAP_EN(1'b0)) dut_s (
        .clk_in(clk_in), .rst_n(rst_n), .slow_clk_in(slow_clk_in), .start_stop(start_stop),
        .up_down(up_down), .clear(clear), .load(load), .load_value(load_value),
        .count_out(s_count), .tick_out(s_tick), .wrap_out(s_wrap), .running_out(s_run)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n posedges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Raise the wave; returns just after the edge that commits the step.
    task automatic tick_rise();
        slow_clk_in = 1'b1;
        step(3);
    endtask

    task automatic tick_fall();
        slow_clk_in = 1'b0;
        step(3);
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        // Reset with wave high
        step(2);
        chk("rst_count", w_count, 16'h0000);
        chk("rst_run", w_run, 1'b0);
        chk("rst_wrap", w_wrap, 1'b0);
        chk("rst_tick", w_tick, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("high_no_tick", w_tick, 1'b0);
        end
        pulse_start();
        chk("start_run", w_run, 1'b1);
        chk("start_count", w_count, 16'h0000);

        // First real edge: tick exactly between N+1 and N+2
        slow_clk_in = 1'b0;
        step(3);
        slow_clk_in = 1'b1;
        step(1);
        chk("lat_n", w_tick, 1'b0);
        step(1);
        chk("lat_n1", w_tick, 1'b1);
        chk("lat_n1_cnt", w_count, 16'h0000);
        step(1);
        chk("lat_n2", w_tick, 1'b0);
        chk("first_step", w_count, 16'h0001);
        step(4);
        chk("long_high_one_tick", w_count, 16'h0001);
        tick_fall();

        // Carry ripple and wrap at MAX
        do_load(16'h0999);
        chk("load_0999", w_count, 16'h0999);
        tick_rise();
        chk("carry_1000", w_count, 16'h1000);
        tick_fall();
        do_load(16'h9999);
        tick_rise();
        chk("wrap_up_cnt", w_count, 16'h0000);
        chk("wrap_up_pulse", w_wrap, 1'b1);
        chk("wrap_up_run", w_run, 1'b1);
        step(1);
        chk("wrap_up_once", w_wrap, 1'b0);
        tick_fall();

        // Down: borrow ripple and wrap at MIN
        up_down = 1'b0;
        do_load(16'h1000);
        tick_rise();
        chk("borrow_0999", w_count, 16'h0999);
        chk("borrow_nowrap", w_wrap, 1'b0);
        tick_fall();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear", w_count, 16'h0000);
        chk("clear_keeps_run", w_run, 1'b1);
        tick_rise();
        chk("wrap_dn_cnt", w_count, 16'h9999);
        chk("wrap_dn_pulse", w_wrap, 1'b1);
        tick_fall();
        up_down = 1'b1;

        // Load clamping and priorities
        do_load(16'hA5F3);
        chk("load_clamp", w_count, 16'h9593);
        slow_clk_in = 1'b1;
        step(2);
        chk("tick_w_load", w_tick, 1'b1);
        load_value = 16'h1234;
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk("load_beats_tick", w_count, 16'h1234);
        step(1);
        chk("load_tick_dropped", w_count, 16'h1234);
        tick_fall();
        clear = 1'b1;
        load = 1'b1;
        load_value = 16'h5555;
        step(1);
        clear = 1'b0;
        load = 1'b0;
        chk("clear_beats_load", w_count, 16'h0000);

        // start_stop coinciding with a tick while STOPPED
        pulse_start();
        chk("stopped", w_run, 1'b0);
        do_load(16'h0010);
        tick_rise();
        chk("stopped_no_step", w_count, 16'h0010);
        tick_fall();
        slow_clk_in = 1'b1;
        step(2);
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
        chk("start_tick_no_step", w_count, 16'h0010);
        chk("start_tick_run", w_run, 1'b1);
        step(1);
        tick_fall();
        tick_rise();
        chk("next_tick_steps", w_count, 16'h0011);
        tick_fall();

        // Mid-count reset
        do_load(16'h0042);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("midrst_count", w_count, 16'h0000);
        chk("midrst_run", w_run, 1'b0);
        step(3);
        tick_rise();
        chk("midrst_no_step", w_count, 16'h0000);
        tick_fall();
        pulse_start();
        tick_rise();
        chk("midrst_restart", w_count, 16'h0001);
        tick_fall();

        // Saturating instance
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        pulse_start();
        up_down = 1'b0;
        do_load(16'h0001);
        chk("sat_load", s_count, 16'h0001);
        tick_rise();
        chk("sat_first", s_count, 16'h0000);
        chk("sat_first_nowrap", s_wrap, 1'b0);
        chk("sat_first_run", s_run, 1'b1);
        tick_fall();
        tick_rise();
        chk("sat_hold", s_count, 16'h0000);
        chk("sat_pulse", s_wrap, 1'b1);
        chk("sat_stopped", s_run, 1'b0);
        step(1);
        chk("sat_pulse_once", s_wrap, 1'b0);
        tick_fall();
        tick_rise();
        chk("sat_idle_cnt", s_count, 16'h0000);
        chk("sat_idle_wrap", s_wrap, 1'b0);
        tick_fall();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
